// File: rtl/riscv_mc_ctrl_if.sv
// Control bus between the multicycle RISC-V controller (master) and its datapath (slave).
// MEM_WAIT_EN adds the mem_ready handshake from memory.
interface riscv_mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op;
   logic [2:0]       funct3;
   logic             funct7b5;
   logic             zero;
`ifdef MEM_WAIT_EN
   logic             mem_ready;
`endif
   logic             PCWrite;
   logic             AdrSrc;
   logic             MemWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ImmSrc;
   logic [2:0]       ALUcontrol;
   logic             illegal_instr;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, funct3, funct7b5, zero,
`ifdef MEM_WAIT_EN
      input  mem_ready,
`endif
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
      output ALUSrcA, ALUSrcB, ImmSrc, ALUcontrol, illegal_instr, instret
   );

   modport slave (
      output op, funct3, funct7b5, zero,
`ifdef MEM_WAIT_EN
      output mem_ready,
`endif
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
      input  ALUSrcA, ALUSrcB, ImmSrc, ALUcontrol, illegal_instr, instret
   );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RISC-V main controller + ALU decoder with retired-instruction counter.
// Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module riscv_mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   riscv_mc_ctrl_if.master  bus
);
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BEQ      = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             mem_ok;

`ifdef MEM_WAIT_EN
   assign mem_ok = bus.mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   logic is_lw, is_sw, is_r, is_i, is_beq, is_jal;
   logic funct_ok, legal;
   logic [2:0] alu_funct;

   assign is_lw  = (bus.op == 7'b0000011);
   assign is_sw  = (bus.op == 7'b0100011);
   assign is_r   = (bus.op == 7'b0110011);
   assign is_i   = (bus.op == 7'b0010011);
   assign is_beq = (bus.op == 7'b1100011);
   assign is_jal = (bus.op == 7'b1101111);

   assign funct_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);

   // funct7b5 only distinguishes sub from add; on any other R-type funct3 it is illegal
   assign legal = ((is_lw || is_sw) && (bus.funct3 == 3'b010))
                || (is_r && funct_ok && !(bus.funct7b5 && (bus.funct3 != 3'b000)))
                || (is_i && funct_ok)
                || (is_beq && (bus.funct3 == 3'b000))
                || is_jal;

   always_comb begin
      alu_funct = ALU_ADD;
      case (bus.funct3)
         3'b000:  alu_funct = (is_r && bus.funct7b5) ? ALU_SUB : ALU_ADD;
         3'b110:  alu_funct = ALU_OR;
         3'b111:  alu_funct = ALU_AND;
         default: alu_funct = ALU_ADD;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ok) state_d = S_DECODE;
         S_DECODE: begin
            if (!legal)                 state_d = S_FETCH;
            else if (is_lw || is_sw)    state_d = S_MEMADR;
            else if (is_r)              state_d = S_EXECR;
            else if (is_i)              state_d = S_EXECI;
            else if (is_beq)            state_d = S_BEQ;
            else                        state_d = S_JAL;
         end
         S_MEMADR:   state_d = is_lw ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
         S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
         S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   logic retire;
   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ)
                || ((state_q == S_MEMWRITE) && mem_ok);
   assign instret_d = retire ? instret_q + 1'b1 : instret_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_ctrl;

   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write   = mem_ok;
            pc_write   = mem_ok;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            illegal   = !legal;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = mem_ok;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_ctrl  = alu_funct;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_ctrl  = alu_funct;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_ctrl  = ALU_SUB;
            pc_write  = bus.zero;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      imm_src = 2'b00;
      if (is_sw)       imm_src = 2'b01;
      else if (is_beq) imm_src = 2'b10;
      else if (is_jal) imm_src = 2'b11;
   end

   // Strobes are masked by rst_n so a reset mid-instruction never lets a write escape
   assign bus.PCWrite       = pc_write  & rst_n;
   assign bus.MemWrite      = mem_write & rst_n;
   assign bus.IRWrite       = ir_write  & rst_n;
   assign bus.RegWrite      = reg_write & rst_n;
   assign bus.illegal_instr = illegal   & rst_n;
   assign bus.AdrSrc        = adr_src;
   assign bus.ResultSrc     = result_src;
   assign bus.ALUSrcA       = alu_src_a;
   assign bus.ALUSrcB       = alu_src_b;
   assign bus.ImmSrc        = imm_src;
   assign bus.ALUcontrol    = alu_ctrl;
   assign bus.instret       = instret_q;
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: stimulus queues expected per-cycle outputs, monitor compares.
module tb_riscv_mc_ctrl;
   typedef struct packed {
      logic        pcw, adr, mw, irw, rw;
      logic [1:0]  res, sa, sb, imm;
      logic [2:0]  alu;
      logic        ill;
      logic [31:0] cnt;
   } row_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   riscv_mc_ctrl_if #(.CNT_W(32)) bus ();
   riscv_mc_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   row_t  exp_q[$];
   logic  all_q[$];
   string name_q[$];
   int    total = 0;
   int    bad = 0;

   logic       tb_rn = 1'b0;
   logic [6:0] tb_op = 7'b0;
   logic [2:0] tb_f3 = 3'b0;
   logic       tb_f7 = 1'b0;
   logic       tb_z  = 1'b0;
   logic       tb_mr = 1'b1;

   function automatic row_t r(input logic pcw, adr, mw, irw, rw,
                              input logic [1:0] res, sa, sb, imm,
                              input logic [2:0] alu, input logic ill, input logic [31:0] cnt);
      row_t v;
      v = {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill, cnt};
      return v;
   endfunction

   task automatic cyc(input row_t e, input logic all, input string nm);
      @(posedge clk);
      #1;
      rst_n        = tb_rn;
      bus.op       = tb_op;
      bus.funct3   = tb_f3;
      bus.funct7b5 = tb_f7;
      bus.zero     = tb_z;
`ifdef MEM_WAIT_EN
      bus.mem_ready = tb_mr;
`endif
      exp_q.push_back(e);
      all_q.push_back(all);
      name_q.push_back(nm);
   endtask

   // monitor: one queued expectation per clock cycle
   initial begin
      row_t act, e, m;
      logic all;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            all = all_q.pop_front();
            nm  = name_q.pop_front();
            m   = all ? '1 : r(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 32'hFFFF_FFFF);
            act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                   bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUcontrol,
                   bus.illegal_instr, bus.instret};
            total++;
            if ((act & m) !== (e & m)) begin
               bad++;
               $display("FAIL %s: got %h want %h mask %h", nm, act, e, m);
            end else begin
               $display("ok   %s: %h", nm, act);
            end
         end
      end
   end

   initial begin
      bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
`ifdef MEM_WAIT_EN
      bus.mem_ready = 1'b1;
`endif
      // reset: strobes and instret only
      tb_rn = 1'b0;
      for (int i = 0; i < 3; i++)
         cyc(r(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,32'd0), 1'b0, "reset");
      tb_rn = 1'b1;

      // sub
      tb_op = 7'b0110011; tb_f3 = 3'b000; tb_f7 = 1'b1;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd0), 1'b1, "sub_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,32'd0), 1'b1, "sub_decode");
      cyc(r(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,32'd0), 1'b1, "sub_execr");
      cyc(r(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,32'd0), 1'b1, "sub_aluwb");

      // lw
      tb_op = 7'b0000011; tb_f3 = 3'b010; tb_f7 = 1'b0;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd1), 1'b1, "lw_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,32'd1), 1'b1, "lw_decode");
      cyc(r(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,32'd1), 1'b1, "lw_memadr");
      cyc(r(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,32'd1), 1'b1, "lw_memread");
      cyc(r(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0,32'd1), 1'b1, "lw_memwb");

      // sw
      tb_op = 7'b0100011; tb_f3 = 3'b010;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,32'd2), 1'b1, "sw_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,32'd2), 1'b1, "sw_decode");
      cyc(r(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,32'd2), 1'b1, "sw_memadr");
      cyc(r(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,32'd2), 1'b1, "sw_memwrite");

      // beq taken, then not taken
      tb_op = 7'b1100011; tb_f3 = 3'b000; tb_z = 1'b1;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,32'd3), 1'b1, "beqt_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,32'd3), 1'b1, "beqt_decode");
      cyc(r(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,32'd3), 1'b1, "beqt_beq");
      tb_z = 1'b0;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,32'd4), 1'b1, "beqn_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,32'd4), 1'b1, "beqn_decode");
      cyc(r(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,32'd4), 1'b1, "beqn_beq");

      // illegal R-type funct3=010
      tb_op = 7'b0110011; tb_f3 = 3'b010;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd5), 1'b1, "ill_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1,32'd5), 1'b1, "ill_decode");

      // ori
      tb_op = 7'b0010011; tb_f3 = 3'b110;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd5), 1'b1, "ori_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,32'd5), 1'b1, "ori_decode");
      cyc(r(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011,0,32'd5), 1'b1, "ori_execi");
      cyc(r(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,32'd5), 1'b1, "ori_aluwb");

      // and (R-type)
      tb_op = 7'b0110011; tb_f3 = 3'b111; tb_f7 = 1'b0;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd6), 1'b1, "and_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,32'd6), 1'b1, "and_decode");
      cyc(r(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0,32'd6), 1'b1, "and_execr");
      cyc(r(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,32'd6), 1'b1, "and_aluwb");

      // jal
      tb_op = 7'b1101111; tb_f3 = 3'b000;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0,32'd7), 1'b1, "jal_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,32'd7), 1'b1, "jal_decode");
      cyc(r(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,32'd7), 1'b1, "jal_jal");
      cyc(r(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0,32'd7), 1'b1, "jal_aluwb");

      // unknown opcode
      tb_op = 7'b0000000;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd8), 1'b1, "badop_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1,32'd8), 1'b1, "badop_decode");

      // addi, with a two-cycle fetch stall when memory wait is built in
      tb_op = 7'b0010011; tb_f3 = 3'b000;
`ifdef MEM_WAIT_EN
      tb_mr = 1'b0;
      cyc(r(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd8), 1'b1, "addi_fetch_hold1");
      cyc(r(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd8), 1'b1, "addi_fetch_hold2");
      tb_mr = 1'b1;
`endif
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd8), 1'b1, "addi_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,32'd8), 1'b1, "addi_decode");
      cyc(r(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,32'd8), 1'b1, "addi_execi");
      cyc(r(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,32'd8), 1'b1, "addi_aluwb");

      // lw abandoned by reset in its MEMWB cycle
      tb_op = 7'b0000011; tb_f3 = 3'b010;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd9), 1'b1, "lwr_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,32'd9), 1'b1, "lwr_decode");
      cyc(r(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,32'd9), 1'b1, "lwr_memadr");
      cyc(r(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,32'd9), 1'b1, "lwr_memread");
      tb_rn = 1'b0;
      cyc(r(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,32'd9), 1'b0, "lwr_reset_gate");
      tb_rn = 1'b1;
      cyc(r(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,32'd0), 1'b1, "post_reset_fetch");
      cyc(r(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,32'd0), 1'b1, "post_reset_decode");

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
